// File: rtl/mem_region_router_pkg.sv
// Shared types for the multi-target memory region router.
package mem_region_router_pkg;

  localparam int unsigned NumLanes = 4;
  localparam int unsigned NumOuts  = 3;
  localparam int unsigned TagWidth = 16;
  localparam int unsigned TgtIdxW  = $clog2(NumOuts);

  typedef logic [TgtIdxW-1:0] tgt_idx_t;

  // One outstanding read: where each lane went and which targets must answer.
  typedef struct packed {
    logic [TagWidth-1:0]           tag;
    logic [NumLanes-1:0]           mask;
    tgt_idx_t [NumLanes-1:0]       map;
    logic [NumOuts-1:0]            tset;
  } trk_entry_t;

endpackage

// File: rtl/mem_region_router_if.sv
// LSU-side and per-target request/response bundle for the region router.
interface mem_region_router_if #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned NUM_OUTS   = 3,
  parameter int unsigned WORD_SIZE  = 4,
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned TAG_WIDTH  = 16
);
  localparam int unsigned WordBits = WORD_SIZE * 8;

  logic                                              in_req_valid;
  logic                                              in_req_ready;
  logic                                              in_req_rw;
  logic [NUM_LANES-1:0]                              in_req_mask;
  logic [NUM_LANES-1:0][WORD_SIZE-1:0]               in_req_byteen;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]              in_req_addr;
  logic [NUM_LANES-1:0][WordBits-1:0]                in_req_data;
  logic [TAG_WIDTH-1:0]                              in_req_tag;

  logic                                              in_rsp_valid;
  logic                                              in_rsp_ready;
  logic [NUM_LANES-1:0]                              in_rsp_mask;
  logic [NUM_LANES-1:0][WordBits-1:0]                in_rsp_data;
  logic [TAG_WIDTH-1:0]                              in_rsp_tag;

  logic [NUM_OUTS-1:0]                               out_req_valid;
  logic [NUM_OUTS-1:0]                               out_req_ready;
  logic [NUM_OUTS-1:0]                               out_req_rw;
  logic [NUM_OUTS-1:0][NUM_LANES-1:0]                out_req_mask;
  logic [NUM_OUTS-1:0][NUM_LANES-1:0][WORD_SIZE-1:0] out_req_byteen;
  logic [NUM_OUTS-1:0][NUM_LANES-1:0][ADDR_WIDTH-1:0] out_req_addr;
  logic [NUM_OUTS-1:0][NUM_LANES-1:0][WordBits-1:0]  out_req_data;
  logic [NUM_OUTS-1:0][TAG_WIDTH-1:0]                out_req_tag;

  logic [NUM_OUTS-1:0]                               out_rsp_valid;
  logic [NUM_OUTS-1:0]                               out_rsp_ready;
  logic [NUM_OUTS-1:0][NUM_LANES-1:0]                out_rsp_mask;
  logic [NUM_OUTS-1:0][NUM_LANES-1:0][WordBits-1:0]  out_rsp_data;

  // Router view.
  modport slave (
    input  in_req_valid, in_req_rw, in_req_mask, in_req_byteen, in_req_addr, in_req_data,
           in_req_tag, in_rsp_ready, out_req_ready, out_rsp_valid, out_rsp_mask, out_rsp_data,
    output in_req_ready, in_rsp_valid, in_rsp_mask, in_rsp_data, in_rsp_tag, out_req_valid,
           out_req_rw, out_req_mask, out_req_byteen, out_req_addr, out_req_data, out_req_tag,
           out_rsp_ready
  );

  // LSU plus targets view.
  modport master (
    output in_req_valid, in_req_rw, in_req_mask, in_req_byteen, in_req_addr, in_req_data,
           in_req_tag, in_rsp_ready, out_req_ready, out_rsp_valid, out_rsp_mask, out_rsp_data,
    input  in_req_ready, in_rsp_valid, in_rsp_mask, in_rsp_data, in_rsp_tag, out_req_valid,
           out_req_rw, out_req_mask, out_req_byteen, out_req_addr, out_req_data, out_req_tag,
           out_rsp_ready
  );
endinterface

// File: rtl/mem_route_tracker.sv
// Outstanding-read FIFO plus the capture/merge stage that rebuilds full-width responses.
module mem_route_tracker
  import mem_region_router_pkg::*;
#(
  parameter int unsigned NUM_LANES  = NumLanes,
  parameter int unsigned NUM_OUTS   = NumOuts,
  parameter int unsigned WORD_SIZE  = 4,
  parameter int unsigned QUEUE_SIZE = 8
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              push_i,
  input  trk_entry_t                                        push_entry_i,
  output logic                                              full_o,
  output logic [$clog2(QUEUE_SIZE):0]                       count_o,
  input  logic [NUM_OUTS-1:0]                               rsp_valid_i,
  output logic [NUM_OUTS-1:0]                               rsp_ready_o,
  input  logic [NUM_OUTS-1:0][NUM_LANES-1:0]                rsp_mask_i,
  input  logic [NUM_OUTS-1:0][NUM_LANES-1:0][WORD_SIZE*8-1:0] rsp_data_i,
  output logic                                              merged_valid_o,
  input  logic                                              merged_ready_i,
  output logic [NUM_LANES-1:0]                              merged_mask_o,
  output logic [NUM_LANES-1:0][WORD_SIZE*8-1:0]             merged_data_o,
  output logic [TagWidth-1:0]                               merged_tag_o
);
  localparam int unsigned PtrW = $clog2(QUEUE_SIZE);
  localparam logic [PtrW:0] FullCnt = QUEUE_SIZE[PtrW:0];

  trk_entry_t                                     fifo_q [QUEUE_SIZE];
  logic [PtrW-1:0]                                wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]                                  count_q, count_d;
  logic [NUM_OUTS-1:0]                            captured_q, captured_d;
  logic                                           merged_valid_q, merged_valid_d;
  logic [NUM_OUTS-1:0][NUM_LANES-1:0][WORD_SIZE*8-1:0] hold_q;

  trk_entry_t          head;
  logic                empty, pop;
  logic [NUM_OUTS-1:0] rsp_fire;

  assign head        = fifo_q[rd_ptr_q];
  assign empty       = (count_q == '0);
  assign full_o      = (count_q == FullCnt);
  assign count_o     = count_q;
  assign pop         = merged_valid_q & merged_ready_i;
  // Only the head entry's targets may answer; later responses stay parked at the targets.
  assign rsp_ready_o = {NUM_OUTS{~empty & ~merged_valid_q}} & head.tset & ~captured_q;
  assign rsp_fire    = rsp_valid_i & rsp_ready_o;

  // Next-state for occupancy and merge progress.
  always_comb begin
    count_d        = count_q + {{PtrW{1'b0}}, push_i} - {{PtrW{1'b0}}, pop};
    captured_d     = captured_q | rsp_fire;
    merged_valid_d = merged_valid_q | (~empty & (captured_d == head.tset));
    if (pop) begin
      captured_d     = '0;
      merged_valid_d = 1'b0;
    end
  end

  // Pointers, occupancy and merge state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      captured_q     <= '0;
      merged_valid_q <= 1'b0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q        <= count_d;
      captured_q     <= captured_d;
      merged_valid_q <= merged_valid_d;
    end
  end

  // Entry storage; validity is tracked by count_q so no reset needed.
  always_ff @(posedge clk) begin
    if (push_i) fifo_q[wr_ptr_q] <= push_entry_i;
  end

  // Capture each answering target's flagged lanes into its hold register.
  always_ff @(posedge clk) begin
    for (int t = 0; t < NUM_OUTS; t++) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (rsp_fire[t] && rsp_mask_i[t][l]) hold_q[t][l] <= rsp_data_i[t][l];
      end
    end
  end

  // Rebuild the full-width response lane by lane from the owning target.
  always_comb begin
    merged_data_o = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      merged_data_o[l] = hold_q[head.map[l]][l];
    end
  end

  assign merged_valid_o = merged_valid_q;
  assign merged_mask_o  = head.mask;
  assign merged_tag_o   = head.tag;

endmodule

// File: rtl/mem_region_router.sv
// Routes LSU request lanes to address-windowed targets and merges their read responses in order.
module mem_region_router
  import mem_region_router_pkg::*;
#(
  parameter int unsigned                      NUM_LANES   = NumLanes,
  parameter int unsigned                      NUM_OUTS    = NumOuts,
  parameter int unsigned                      WORD_SIZE   = 4,
  parameter int unsigned                      ADDR_WIDTH  = 30,
  parameter int unsigned                      TAG_WIDTH   = TagWidth,
  parameter logic [NUM_OUTS*ADDR_WIDTH-1:0]   REGION_BASE = '0,
  parameter logic [NUM_OUTS*ADDR_WIDTH-1:0]   REGION_MASK = '0,
  parameter int unsigned                      QUEUE_SIZE  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  mem_region_router_if.slave            bus,
  output logic [$clog2(QUEUE_SIZE):0]   pending_count
);
  tgt_idx_t [NUM_LANES-1:0]           lane_tgt;
  logic [NUM_OUTS-1:0][NUM_LANES-1:0] sub_mask;
  logic [NUM_OUTS-1:0]                tset;
  logic                               targets_ready, is_read, accept_ok, trk_full, trk_push;
  trk_entry_t                         push_entry;
  logic [TAG_WIDTH-1:0]               rsp_tag;

  // Lane routing: lowest matching window from 1 upward wins, otherwise the default target 0.
  always_comb begin
    lane_tgt = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int t = NUM_OUTS - 1; t >= 1; t--) begin
        if ((bus.in_req_addr[l] & REGION_MASK[t*ADDR_WIDTH +: ADDR_WIDTH]) ==
            (REGION_BASE[t*ADDR_WIDTH +: ADDR_WIDTH] & REGION_MASK[t*ADDR_WIDTH +: ADDR_WIDTH])) begin
          lane_tgt[l] = tgt_idx_t'(t);
        end
      end
    end
  end

  // Per-target lane masks and the set of targets this request touches.
  always_comb begin
    sub_mask = '0;
    tset     = '0;
    for (int t = 0; t < NUM_OUTS; t++) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        sub_mask[t][l] = bus.in_req_mask[l] & (lane_tgt[l] == tgt_idx_t'(t));
      end
      tset[t] = |sub_mask[t];
    end
  end

  // All-or-nothing issue; zero-mask and write requests never occupy the tracker.
  assign targets_ready    = &(~tset | bus.out_req_ready);
  assign is_read          = ~bus.in_req_rw & (|bus.in_req_mask);
  assign accept_ok        = targets_ready & (~is_read | ~trk_full);
  assign bus.in_req_ready = accept_ok;
  assign trk_push         = bus.in_req_valid & accept_ok & is_read;

  // Broadcast request fields; only valid and mask differ per target.
  always_comb begin
    for (int t = 0; t < NUM_OUTS; t++) begin
      bus.out_req_valid[t]  = bus.in_req_valid & tset[t] & accept_ok;
      bus.out_req_rw[t]     = bus.in_req_rw;
      bus.out_req_mask[t]   = sub_mask[t];
      bus.out_req_byteen[t] = bus.in_req_byteen;
      bus.out_req_addr[t]   = bus.in_req_addr;
      bus.out_req_data[t]   = bus.in_req_data;
      bus.out_req_tag[t]    = bus.in_req_tag;
    end
  end

  assign push_entry = '{tag: bus.in_req_tag, mask: bus.in_req_mask, map: lane_tgt, tset: tset};

  mem_route_tracker #(
    .NUM_LANES  (NUM_LANES),
    .NUM_OUTS   (NUM_OUTS),
    .WORD_SIZE  (WORD_SIZE),
    .QUEUE_SIZE (QUEUE_SIZE)
  ) u_tracker (
    .clk            (clk),
    .reset          (reset),
    .push_i         (trk_push),
    .push_entry_i   (push_entry),
    .full_o         (trk_full),
    .count_o        (pending_count),
    .rsp_valid_i    (bus.out_rsp_valid),
    .rsp_ready_o    (bus.out_rsp_ready),
    .rsp_mask_i     (bus.out_rsp_mask),
    .rsp_data_i     (bus.out_rsp_data),
    .merged_valid_o (bus.in_rsp_valid),
    .merged_ready_i (bus.in_rsp_ready),
    .merged_mask_o  (bus.in_rsp_mask),
    .merged_data_o  (bus.in_rsp_data),
    .merged_tag_o   (rsp_tag)
  );

  assign bus.in_rsp_tag = rsp_tag;

endmodule

// File: tb/tb_mem_region_router.sv
// Scoreboard bench for mem_region_router: expected merged responses are queued at issue time.
module tb_mem_region_router;
  import mem_region_router_pkg::*;

  localparam int unsigned Lanes = 4;
  localparam int unsigned Outs  = 3;
  localparam int unsigned Ws    = 4;
  localparam int unsigned Aw    = 30;
  localparam int unsigned Tw    = 16;
  localparam int unsigned Qs    = 8;
  localparam logic [Outs*Aw-1:0] Base = {30'h0010_0000, 30'h0000_1000, 30'h0};
  localparam logic [Outs*Aw-1:0] Mask = {30'h03F0_0000, 30'h0003_F000, 30'h0};

  typedef logic [Lanes-1:0][31:0] lane_data_t;
  typedef logic [Lanes-1:0][Aw-1:0] lane_addr_t;
  typedef struct {
    logic [Tw-1:0]    tag;
    logic [Lanes-1:0] mask;
    lane_data_t       data;
  } exp_rsp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pending_count;
  int         total = 0;
  int         bad = 0;
  exp_rsp_t   exp_q [$];

  mem_region_router_if #(
    .NUM_LANES (Lanes), .NUM_OUTS (Outs), .WORD_SIZE (Ws), .ADDR_WIDTH (Aw), .TAG_WIDTH (Tw)
  ) bus ();

  mem_region_router #(
    .NUM_LANES   (Lanes),
    .NUM_OUTS    (Outs),
    .WORD_SIZE   (Ws),
    .ADDR_WIDTH  (Aw),
    .TAG_WIDTH   (Tw),
    .REGION_BASE (Base),
    .REGION_MASK (Mask),
    .QUEUE_SIZE  (Qs)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .pending_count (pending_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Response monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && bus.in_rsp_valid && bus.in_rsp_ready) begin
      exp_rsp_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got tag=%h mask=%b, none expected", bus.in_rsp_tag,
                 bus.in_rsp_mask);
      end else begin
        e = exp_q.pop_front();
        if (bus.in_rsp_tag !== e.tag || bus.in_rsp_mask !== e.mask || bus.in_rsp_data !== e.data)
        begin
          bad++;
          $display("FAIL rsp_match: got tag=%h mask=%b data=%h, want tag=%h mask=%b data=%h",
                   bus.in_rsp_tag, bus.in_rsp_mask, bus.in_rsp_data, e.tag, e.mask, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic lane_data_t tgt_data(input int t, input logic [7:0] salt);
    lane_data_t d;
    for (int l = 0; l < Lanes; l++) d[l] = {8'hD0 + 8'(t), salt, 8'h00, 8'(l)};
    return d;
  endfunction

  task automatic idle_inputs();
    bus.in_req_valid  = 1'b0;
    bus.in_req_rw     = 1'b0;
    bus.in_req_mask   = '0;
    bus.in_req_byteen = '1;
    bus.in_req_addr   = '0;
    bus.in_req_data   = '0;
    bus.in_req_tag    = '0;
    bus.in_rsp_ready  = 1'b1;
    bus.out_req_ready = '1;
    bus.out_rsp_valid = '0;
    bus.out_rsp_mask  = '0;
    bus.out_rsp_data  = '0;
  endtask

  task automatic drive_req(input logic rw, input logic [Lanes-1:0] mask, input lane_addr_t addr,
                           input logic [Tw-1:0] tag);
    bus.in_req_valid = 1'b1;
    bus.in_req_rw    = rw;
    bus.in_req_mask  = mask;
    bus.in_req_addr  = addr;
    bus.in_req_tag   = tag;
    bus.in_req_data  = tgt_data(7, tag[7:0]);
  endtask

  function automatic lane_addr_t split_addr();
    lane_addr_t a;
    a[0] = 30'h1000;
    a[1] = 30'h0;
    a[2] = 30'h1010;
    a[3] = 30'h8;
    return a;
  endfunction

  function automatic exp_rsp_t split_exp(input logic [Tw-1:0] tag, input lane_data_t d0,
                                         input lane_data_t d1);
    exp_rsp_t e;
    e.tag     = tag;
    e.mask    = 4'b1111;
    e.data[0] = d1[0];
    e.data[1] = d0[1];
    e.data[2] = d1[2];
    e.data[3] = d0[3];
    return e;
  endfunction

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (bus.in_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_in_rsp_valid: got %b want 0", bus.in_rsp_valid);
    end
    total++;
    if (bus.out_req_valid !== 3'b000) begin
      bad++; $display("FAIL reset_out_req_valid: got %b want 000", bus.out_req_valid);
    end
    total++;
    if (bus.out_rsp_ready !== 3'b000) begin
      bad++; $display("FAIL reset_out_rsp_ready: got %b want 000", bus.out_rsp_ready);
    end
    total++;
    if (pending_count !== 4'd0) begin
      bad++; $display("FAIL reset_pending: got %0d want 0", pending_count);
    end
    reset = 1'b0;
    tick();
    total++;
    if (bus.in_req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_req_ready: got %b want 1", bus.in_req_ready);
    end
  endtask

  task automatic test_split_read();
    lane_data_t d0 = tgt_data(0, 8'h11);
    lane_data_t d1 = tgt_data(1, 8'h11);
    drive_req(1'b0, 4'b1111, split_addr(), 16'h1234);
    #1;
    total++;
    if (bus.in_req_ready !== 1'b1 || bus.out_req_valid !== 3'b011) begin
      bad++; $display("FAIL split_issue: got ready=%b valid=%b want 1/011", bus.in_req_ready,
                      bus.out_req_valid);
    end
    total++;
    if (bus.out_req_mask[0] !== 4'b1010 || bus.out_req_mask[1] !== 4'b0101) begin
      bad++; $display("FAIL split_masks: got t0=%b t1=%b want 1010/0101", bus.out_req_mask[0],
                      bus.out_req_mask[1]);
    end
    total++;
    if (bus.out_req_tag[1] !== 16'h1234) begin
      bad++; $display("FAIL split_tag: got %h want 1234", bus.out_req_tag[1]);
    end
    exp_q.push_back(split_exp(16'h1234, d0, d1));
    tick();
    bus.in_req_valid = 1'b0;
    total++;
    if (pending_count !== 4'd1) begin
      bad++; $display("FAIL split_pending: got %0d want 1", pending_count);
    end
    bus.out_rsp_valid[1] = 1'b1;
    bus.out_rsp_mask[1]  = 4'b0101;
    bus.out_rsp_data[1]  = d1;
    #1;
    total++;
    if (bus.out_rsp_ready !== 3'b011) begin
      bad++; $display("FAIL split_rsp_ready: got %b want 011", bus.out_rsp_ready);
    end
    tick();
    bus.out_rsp_valid[1] = 1'b0;
    repeat (3) tick();
    total++;
    if (bus.in_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL split_partial: got in_rsp_valid=%b want 0", bus.in_rsp_valid);
    end
    bus.out_rsp_valid[0] = 1'b1;
    bus.out_rsp_mask[0]  = 4'b1010;
    bus.out_rsp_data[0]  = d0;
    tick();
    bus.out_rsp_valid[0] = 1'b0;
    total++;
    if (bus.in_rsp_valid !== 1'b1) begin
      bad++; $display("FAIL split_latency: got in_rsp_valid=%b want 1", bus.in_rsp_valid);
    end
    tick();
    total++;
    if (bus.in_rsp_valid !== 1'b0 || pending_count !== 4'd0) begin
      bad++; $display("FAIL split_done: got valid=%b pending=%0d want 0/0", bus.in_rsp_valid,
                      pending_count);
    end
  endtask

  task automatic test_all_ready();
    lane_data_t d0 = tgt_data(0, 8'h22);
    lane_data_t d1 = tgt_data(1, 8'h22);
    bus.out_req_ready = 3'b101;
    drive_req(1'b0, 4'b1111, split_addr(), 16'h0022);
    #1;
    total++;
    if (bus.in_req_ready !== 1'b0 || bus.out_req_valid !== 3'b000) begin
      bad++; $display("FAIL partial_ready_block: got ready=%b valid=%b want 0/000",
                      bus.in_req_ready, bus.out_req_valid);
    end
    tick();
    tick();
    total++;
    if (bus.out_req_valid !== 3'b000 || pending_count !== 4'd0) begin
      bad++; $display("FAIL partial_ready_hold: got valid=%b pending=%0d want 000/0",
                      bus.out_req_valid, pending_count);
    end
    bus.out_req_ready = 3'b111;
    #1;
    total++;
    if (bus.in_req_ready !== 1'b1 || bus.out_req_valid !== 3'b011) begin
      bad++; $display("FAIL partial_ready_release: got ready=%b valid=%b want 1/011",
                      bus.in_req_ready, bus.out_req_valid);
    end
    exp_q.push_back(split_exp(16'h0022, d0, d1));
    tick();
    bus.in_req_valid  = 1'b0;
    bus.out_rsp_valid = 3'b011;
    bus.out_rsp_mask  = {4'b0000, 4'b0101, 4'b1010};
    bus.out_rsp_data  = {tgt_data(2, 8'h22), d1, d0};
    tick();
    bus.out_rsp_valid = '0;
    tick();
    total++;
    if (pending_count !== 4'd0) begin
      bad++; $display("FAIL partial_ready_done: got pending=%0d want 0", pending_count);
    end
  endtask

  task automatic test_full();
    lane_data_t d0 = tgt_data(0, 8'h33);
    exp_rsp_t   e;
    e.mask = 4'b1111;
    e.data = d0;
    for (int i = 0; i < 8; i++) begin
      drive_req(1'b0, 4'b1111, '0, 16'h0100 + 16'(i));
      e.tag = 16'h0100 + 16'(i);
      exp_q.push_back(e);
      tick();
    end
    bus.in_req_valid = 1'b0;
    total++;
    if (pending_count !== 4'd8) begin
      bad++; $display("FAIL full_count: got %0d want 8", pending_count);
    end
    drive_req(1'b0, 4'b1111, '0, 16'h0108);
    #1;
    total++;
    if (bus.in_req_ready !== 1'b0 || bus.out_req_valid !== 3'b000) begin
      bad++; $display("FAIL full_block: got ready=%b valid=%b want 0/000", bus.in_req_ready,
                      bus.out_req_valid);
    end
    bus.out_rsp_valid[0] = 1'b1;
    bus.out_rsp_mask[0]  = 4'b1111;
    bus.out_rsp_data[0]  = d0;
    tick();
    bus.out_rsp_valid[0] = 1'b0;
    total++;
    if (bus.in_rsp_valid !== 1'b1 || bus.in_req_ready !== 1'b0) begin
      bad++; $display("FAIL full_pop_same_cycle: got rsp_valid=%b req_ready=%b want 1/0",
                      bus.in_rsp_valid, bus.in_req_ready);
    end
    tick();
    total++;
    if (pending_count !== 4'd7 || bus.in_req_ready !== 1'b1) begin
      bad++; $display("FAIL full_release: got pending=%0d ready=%b want 7/1", pending_count,
                      bus.in_req_ready);
    end
    e.tag = 16'h0108;
    exp_q.push_back(e);
    tick();
    bus.in_req_valid = 1'b0;
    total++;
    if (pending_count !== 4'd8) begin
      bad++; $display("FAIL full_refill: got %0d want 8", pending_count);
    end
    bus.out_rsp_valid[0] = 1'b1;
    for (int c = 0; c < 200 && pending_count != 4'd0; c++) tick();
    bus.out_rsp_valid[0] = 1'b0;
    total++;
    if (pending_count !== 4'd0 || exp_q.size() != 0) begin
      bad++; $display("FAIL full_drain: got pending=%0d queued=%0d want 0/0", pending_count,
                      exp_q.size());
    end
  endtask

  task automatic test_write();
    lane_addr_t a = '0;
    a[0] = 30'h0010_0000;
    a[1] = 30'h0010_0004;
    drive_req(1'b1, 4'b0011, a, 16'h0777);
    #1;
    total++;
    if (bus.in_req_ready !== 1'b1 || bus.out_req_valid !== 3'b100) begin
      bad++; $display("FAIL write_issue: got ready=%b valid=%b want 1/100", bus.in_req_ready,
                      bus.out_req_valid);
    end
    total++;
    if (bus.out_req_mask[2] !== 4'b0011 || bus.out_req_data[2] !== tgt_data(7, 8'h77)) begin
      bad++; $display("FAIL write_fields: got mask=%b data=%h want 0011/%h", bus.out_req_mask[2],
                      bus.out_req_data[2], tgt_data(7, 8'h77));
    end
    tick();
    bus.in_req_valid = 1'b0;
    repeat (4) tick();
    total++;
    if (pending_count !== 4'd0 || bus.in_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL write_untracked: got pending=%0d rsp_valid=%b want 0/0",
                      pending_count, bus.in_rsp_valid);
    end
  endtask

  task automatic test_zero_mask();
    drive_req(1'b0, 4'b0000, split_addr(), 16'h0999);
    #1;
    total++;
    if (bus.in_req_ready !== 1'b1 || bus.out_req_valid !== 3'b000) begin
      bad++; $display("FAIL zero_mask_issue: got ready=%b valid=%b want 1/000", bus.in_req_ready,
                      bus.out_req_valid);
    end
    tick();
    bus.in_req_valid = 1'b0;
    repeat (3) tick();
    total++;
    if (pending_count !== 4'd0 || bus.in_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL zero_mask_silent: got pending=%0d rsp_valid=%b want 0/0",
                      pending_count, bus.in_rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.in_rsp_ready = 1'b0;
    drive_req(1'b0, 4'b0001, '0, 16'h00A0);
    tick();
    drive_req(1'b0, 4'b0001, '0, 16'h00A1);
    tick();
    bus.in_req_valid     = 1'b0;
    bus.out_rsp_valid[0] = 1'b1;
    bus.out_rsp_mask[0]  = 4'b0001;
    bus.out_rsp_data[0]  = tgt_data(0, 8'h44);
    repeat (3) tick();
    total++;
    if (bus.in_rsp_valid !== 1'b1 || bus.out_rsp_ready !== 3'b000 || pending_count !== 4'd2)
    begin
      bad++; $display("FAIL backpressure: got rsp_valid=%b rsp_ready=%b pending=%0d want 1/000/2",
                      bus.in_rsp_valid, bus.out_rsp_ready, pending_count);
    end
    reset = 1'b1;
    tick();
    total++;
    if (bus.in_rsp_valid !== 1'b0 || bus.out_req_valid !== 3'b000 ||
        bus.out_rsp_ready !== 3'b000 || pending_count !== 4'd0) begin
      bad++; $display("FAIL mid_reset: got rsp_valid=%b req_valid=%b rsp_ready=%b pending=%0d",
                      bus.in_rsp_valid, bus.out_req_valid, bus.out_rsp_ready, pending_count);
    end
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_split_read();
    test_all_ready();
    test_full();
    test_write();
    test_zero_mask();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL leftover_expected: got %0d queued want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_region_router.md
Name: mem_region_router

Overview:
- Parametrised successor to the fixed two-way local/global LSU switch: routes each lane of a multi-lane LSU request to one of NUM_OUTS targets (e.g. dcache, lmem, mmio) by address window.
- Merges the per-target read responses back into one in-order, full-width LSU response.
- Sits between the LSU memory interface and the per-target coalescers/adapters inside the memory unit.

Parameters:
- NUM_LANES, 4, lanes per LSU request.
- NUM_OUTS, 3, number of targets (>=2); target 0 is the default.
- WORD_SIZE, 4, bytes per lane.
- ADDR_WIDTH, 30, word-address width per lane.
- TAG_WIDTH, 16, request tag width.
- REGION_BASE, 0, packed NUM_OUTS*ADDR_WIDTH; base address of target t (entry 0 ignored).
- REGION_MASK, 0, packed NUM_OUTS*ADDR_WIDTH; compare mask of target t (entry 0 ignored).
- QUEUE_SIZE, 8, outstanding read entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_req_valid/in_req_ready  in/out  1/1  LSU request handshake
- in_req_rw  in  1  1 = write
- in_req_mask  in  NUM_LANES  active lanes
- in_req_byteen  in  NUM_LANES*WORD_SIZE  byte enables
- in_req_addr  in  NUM_LANES*ADDR_WIDTH  lane addresses
- in_req_data  in  NUM_LANES*WORD_SIZE*8  write data
- in_req_tag  in  TAG_WIDTH  request tag
- in_rsp_valid/in_rsp_ready  out/in  1/1  merged response handshake
- in_rsp_mask  out  NUM_LANES  responding lanes
- in_rsp_data  out  NUM_LANES*WORD_SIZE*8  read data
- in_rsp_tag  out  TAG_WIDTH  original tag
- out_req_valid/out_req_ready  out/in  NUM_OUTS each  per-target request handshake
- out_req_rw, out_req_mask, out_req_byteen, out_req_addr, out_req_data, out_req_tag  out  NUM_OUTS x in_req widths  per-target request fields
- out_rsp_valid/out_rsp_ready  in/out  NUM_OUTS each  per-target response handshake
- out_rsp_mask, out_rsp_data  in  NUM_OUTS x NUM_LANES, NUM_OUTS x NUM_LANES*WORD_SIZE*8  per-target response lanes/data
- pending_count  out  clog2(QUEUE_SIZE)+1  occupied tracker entries

Behaviour:
- Lane routing, combinational: lane l goes to target = lowest t>=1 with (addr_l & MASK_t) == (BASE_t & MASK_t), else 0.
- tset = set of targets with >=1 active lane.
- Target t's sub-request: mask = active lanes routed to t; all other fields broadcast unchanged.
- out_req_valid[t] = in_req_valid & tset[t] & accept_ok.
- accept_ok = all targets in tset have out_req_ready, and (write, or tracker not full).
- in_req_ready = accept_ok. All sub-requests issue in the same cycle; no partial issue.
- Zero-mask request: accepted immediately, nothing issued, nothing tracked, no response.
- Writes: issued, never tracked, produce no response. Targets return no write responses.
- Read accept: push tracker entry {tag, mask, lane->target map, tset}. A full tracker blocks reads even if a pop happens the same cycle.
- Targets respond in order per target. A target's out_rsp_tag is ignored; tag/mask come from the tracker.
- Merge, head entry H:
  - out_rsp_ready[t] = tset_H[t] & ~captured[t] & ~merged_valid.
  - On target handshake, store lane data in hold register t and set captured[t].
  - When captured == tset_H: merged_valid is registered next cycle. Minimum latency is 1 cycle from the last target response to in_rsp_valid.
  - in_rsp_data lane l = hold[map_H[l]] lane l; mask = mask_H.
  - On in_rsp handshake: pop, clear captured and merged_valid.
- Responses for non-head entries wait at the targets (backpressure), never dropped.
- Simultaneous read push and pop: allowed when not full; pending_count unchanged.
- Reset: tracker empty, captured = 0, merged_valid = 0.
  - Reset outputs: in_rsp_valid = 0, out_req_valid = 0, out_rsp_ready = 0, pending_count = 0.
  - Reset mid-operation discards all outstanding entries; targets are reset together.

Decomposition:
- Shared package holds the tracker entry struct (tag, mask, map, tset) and the target-index width constant clog2(NUM_OUTS).
- One sub-module: mem_route_tracker, a QUEUE_SIZE-deep entry FIFO plus the capture/merge register stage.

Test Plan:
- NUM_OUTS=3, region1 base 0x1000 mask 0x3F000: 4-lane read with lanes 0,2 at 0x1000+ and lanes 1,3 at 0x0 -> target0 mask 0b1010, target1 mask 0b0101, same cycle. Target1 responds 3 cycles before target0 -> one in_rsp, mask 0b1111, data interleaved correctly, tag matches.
- Target1 out_req_ready=0 while target0 ready -> in_req_ready=0, no out_req_valid on either target until both are ready.
- Eight reads to target0 only with responses stalled -> 9th read blocked, pending_count=8. Release one response -> pending_count drops, 9th read accepted.
- Write to lanes in target2 -> out_req_valid[2] only, pending_count stays 0, no in_rsp.
- Mask=0 read -> accepted in 1 cycle, no output valid, no response.
- Two reads outstanding with in_rsp_ready=0 -> second response held at targets. Assert reset -> all valids 0 and pending_count=0 the next cycle.
